// File: rtl/msx_bus_pkg.sv
// msx_bus_pkg: shared FSM states, slot addresses and page-field helper for the MSX bus responder
package msx_bus_pkg;
  typedef enum logic [2:0] {IDLE, M1WAIT, REQ, ACKWAIT, HOLD} state_t;
  localparam logic [7:0] DEF_IO_SLOT_PORT = 8'hA8;
  localparam logic [15:0] SUBSLOT_ADDR = 16'hFFFF;
  function automatic logic [1:0] page_field(input logic [7:0] r, input logic [1:0] page);
    return r[{page, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/msx_slot_regs.sv
// msx_slot_regs: primary slot register and page-to-slot mapping; SUBSLOT_EN adds the slot-3 secondary register
module msx_slot_regs
  import msx_bus_pkg::*;
(
  input logic clk,
  input logic reset_n,
  input logic slot_we,
`ifdef SUBSLOT_EN
  input logic subslot_we,
  output logic [7:0] subslot_reg,
`endif
  input logic [7:0] wdata,
  input logic [1:0] page,
  output logic [7:0] slot_reg,
  output logic [1:0] mem_slot,
  output logic [1:0] mem_subslot
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) slot_reg <= 8'h00;
    else if (slot_we) slot_reg <= wdata;
  assign mem_slot = page_field(slot_reg, page);
`ifdef SUBSLOT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) subslot_reg <= 8'h00;
    else if (subslot_we) subslot_reg <= wdata;
  assign mem_subslot = (mem_slot == 2'd3) ? page_field(subslot_reg, page) : 2'd0;
`else
  assign mem_subslot = 2'd0;
`endif
endmodule

// File: rtl/msx_bus_responder.sv
// msx_bus_responder: Z80 bus target for MSX1 (slot port, M1 wait, req/ack back-end); SUBSLOT_EN enables the FFFFh secondary slot register
module msx_bus_responder
  import msx_bus_pkg::*;
#(
  parameter int M1_WAITS = 1,
  parameter logic [7:0] IO_SLOT_PORT = DEF_IO_SLOT_PORT
) (
  input logic clk,
  input logic reset_n,
  input logic ce_3m58_p,
  input logic [15:0] a,
  input logic [7:0] d_from_cpu,
  input logic mreq_n,
  input logic iorq_n,
  input logic rd_n,
  input logic wr_n,
  input logic m1_n,
  input logic rfrsh_n,
  output logic [7:0] d_to_cpu,
  output logic wait_n,
  output logic mem_req,
  output logic mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic [1:0] mem_slot,
  output logic [1:0] mem_subslot,
  input logic [7:0] mem_rdata,
  input logic mem_ack,
  output logic [7:0] slot_reg
);
  state_t state, state_n;
  logic mem_term, io_term, mem_strb, io_strb, mem_start, io_start, io_hit, slot_we;
  logic wait_lo, rel, take_ack, sub_hit, sub_rd;
  logic [7:0] cnt, sub_rdata;
  assign mem_term = !mreq_n & rfrsh_n & (!rd_n | !wr_n);
  assign io_term = !iorq_n & m1_n & (!rd_n | !wr_n);
  assign mem_start = mem_term & !mem_strb;
  assign io_start = io_term & !io_strb;
  assign io_hit = a[7:0] == IO_SLOT_PORT;
  assign slot_we = io_start & !wr_n & io_hit;
  assign mem_req = state == REQ;
  assign sub_rd = wait_lo & sub_hit & !rd_n;
`ifdef SUBSLOT_EN
  logic [7:0] subslot_reg;
  logic sub_we;
  assign sub_hit = mem_slot == 2'd3 && a == SUBSLOT_ADDR;
  assign sub_we = wait_lo & sub_hit & !wr_n;
  assign sub_rdata = ~subslot_reg;
`else
  assign sub_hit = 1'b0;
  assign sub_rdata = 8'hFF;
`endif
  msx_slot_regs u_slot (
    .clk(clk),
    .reset_n(reset_n),
    .slot_we(slot_we),
`ifdef SUBSLOT_EN
    .subslot_we(sub_we),
    .subslot_reg(subslot_reg),
`endif
    .wdata(d_from_cpu),
    .page(a[15:14]),
    .slot_reg(slot_reg),
    .mem_slot(mem_slot),
    .mem_subslot(mem_subslot)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    wait_lo = 1'b0;
    rel = 1'b0;
    take_ack = 1'b0;
    case (state)
      IDLE: if (mem_start) begin
        wait_lo = 1'b1;
        state_n = sub_hit ? HOLD : (!m1_n && M1_WAITS != 0) ? M1WAIT : REQ;
      end
      M1WAIT: if (mreq_n) begin
        rel = 1'b1;
        state_n = IDLE;
      end else if (ce_3m58_p && cnt == 8'(M1_WAITS - 1)) state_n = REQ;
      REQ, ACKWAIT: if (mreq_n) begin
        rel = 1'b1;
        state_n = IDLE;
      end else if (mem_ack) begin
        take_ack = 1'b1;
        rel = 1'b1;
        state_n = HOLD;
      end else state_n = ACKWAIT;
      HOLD: begin
        rel = 1'b1;
        state_n = mreq_n ? IDLE : HOLD;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_strb <= 1'b0;
      io_strb <= 1'b0;
      cnt <= 8'd0;
      wait_n <= 1'b1;
      d_to_cpu <= 8'hFF;
      mem_we <= 1'b0;
      mem_addr <= 16'h0000;
      mem_wdata <= 8'h00;
    end else begin
      mem_strb <= mem_term;
      io_strb <= io_term;
      cnt <= (state == M1WAIT) ? cnt + {7'd0, ce_3m58_p} : 8'd0;
      wait_n <= wait_lo ? 1'b0 : rel ? 1'b1 : wait_n;
      if (wait_lo) begin
        mem_addr <= a;
        mem_wdata <= d_from_cpu;
        mem_we <= !wr_n;
      end
      d_to_cpu <= (take_ack && !mem_we) ? mem_rdata :
                  sub_rd ? sub_rdata :
                  (io_start && !rd_n) ? (io_hit ? slot_reg : 8'hFF) :
                  (!iorq_n && !m1_n) ? 8'hFF : d_to_cpu;
    end
endmodule
